// File: rtl/multi_seq_detect.sv
// Serial multi-pattern detector: NUM_PAT runtime-programmable WIDTH-bit patterns on one bit stream.
// Latency: detected/hit_count are registered, one edge after the bit is accepted.
// No backpressure: a bit is consumed whenever in_valid is high. Optional MULTI_SEQ_HIT_COUNT_EN builds hit counters.
module multi_seq_detect #(
  parameter int WIDTH   = 4,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  localparam int IW     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int FW     = $clog2(WIDTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in,
  input  logic                     in_valid,
  input  logic                     clear,
  input  logic                     overlap,
  input  logic                     cfg_we,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [WIDTH-1:0]         cfg_pattern,
  input  logic                     cfg_en,
  output logic [NUM_PAT-1:0]       detected,
  output logic [NUM_PAT*CNT_W-1:0] hit_count
);

  logic [WIDTH-1:0]   hist;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   pat  [NUM_PAT];
  logic [NUM_PAT-1:0] en;
  logic [FW-1:0]      fill [NUM_PAT];
  logic [NUM_PAT-1:0] match;

  assign cand = {hist[WIDTH-2:0], in};

  // A channel matches when the current bit completes its pattern with enough fresh history behind it.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      match[k] = in_valid && en[k] && (fill[k] >= FW'(WIDTH - 1)) && (cand == pat[k]);
    end
  end

  // Shift register of accepted bits, newest at the LSB; clear drops the bit of the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (in_valid) begin
      hist <= cand;
    end
  end

  // Match pulses are registered and last exactly one cycle per accepted bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      detected <= '0;
    end else begin
      detected <= clear ? '0 : match;
    end
  end

  // Pattern and enable storage; clear leaves these intact.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en <= '0;
      for (int k = 0; k < NUM_PAT; k++) pat[k] <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        if (cfg_idx == IW'(k)) begin
          pat[k] <= cfg_pattern;
          en[k]  <= cfg_en;
        end
      end
    end
  end

  // Per-channel fill: counts fresh bits, restarts on reconfig or non-overlapping match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PAT; k++) fill[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PAT; k++) begin
        if (clear) begin
          fill[k] <= '0;
        end else if (cfg_we && (cfg_idx == IW'(k))) begin
          fill[k] <= '0;
        end else if (in_valid) begin
          if (match[k]) begin
            fill[k] <= overlap ? FW'(WIDTH) : '0;
          end else if (fill[k] != FW'(WIDTH)) begin
            fill[k] <= fill[k] + 1'b1;
          end
        end
      end
    end
  end

`ifdef MULTI_SEQ_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_PAT];

  // Saturating hit counters advance alongside the detected pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PAT; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PAT; k++) begin
        if (clear) begin
          cnt[k] <= '0;
        end else if (match[k] && (cnt[k] != {CNT_W{1'b1}})) begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PAT; g++) begin : g_hc
    assign hit_count[g*CNT_W +: CNT_W] = cnt[g];
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_multi_seq_detect.sv
// Bench for multi_seq_detect: directed scenarios plus random traffic against a bit-list reference model.
// Expected outputs are queued by the driver and popped by a monitor on the falling edge.
// Counters are modelled only when MULTI_SEQ_HIT_COUNT_EN is defined; otherwise zero is expected.
module tb_multi_seq_detect;
  localparam int WIDTH   = 4;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;
  localparam int IW      = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     in_bit = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     clear = 1'b0;
  logic                     overlap = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [IW-1:0]            cfg_idx = '0;
  logic [WIDTH-1:0]         cfg_pattern = '0;
  logic                     cfg_en = 1'b0;
  logic [NUM_PAT-1:0]       detected;
  logic [NUM_PAT*CNT_W-1:0] hit_count;

  multi_seq_detect #(.WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .in(in_bit), .in_valid(in_valid), .clear(clear),
    .overlap(overlap), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .cfg_en(cfg_en), .detected(detected), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_PAT-1:0]       det;
    logic [NUM_PAT*CNT_W-1:0] hc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  // Reference model state: list of accepted bits, per-channel fresh-bit counts, counters.
  int               m_hist[$];
  int               m_fresh[NUM_PAT];
  int               m_cnt[NUM_PAT];
  logic [WIDTH-1:0] m_pat[NUM_PAT];
  logic             m_en[NUM_PAT];

  function automatic void model_reset();
    m_hist.delete();
    for (int k = 0; k < NUM_PAT; k++) begin
      m_fresh[k] = 0; m_cnt[k] = 0; m_pat[k] = '0; m_en[k] = 1'b0;
    end
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: every falling edge with a pending expectation compares the registered outputs.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("detected", 64'(detected), 64'(e.det));
      check("hit_count", 64'(hit_count), 64'(e.hc));
      if (detected !== '0) n_pulses++;
    end
  end

  // One cycle of stimulus: drive inputs, evaluate the model, queue the expected outputs.
  task automatic step(input logic b, input logic v, input logic c,
                      input logic we, input int idx, input logic [WIDTH-1:0] p, input logic e);
    exp_t ex;
    logic [NUM_PAT-1:0] det;
    @(negedge clock); #1;
    in_bit = b; in_valid = v; clear = c;
    cfg_we = we; cfg_idx = IW'(idx); cfg_pattern = p; cfg_en = e;
    det = '0;
    if (v && !c) begin
      for (int k = 0; k < NUM_PAT; k++) begin
        int word = b;
        for (int j = 1; j < WIDTH; j++) begin
          int pos = m_hist.size() - j;
          if (pos >= 0) word += m_hist[pos] << j;
        end
        if (m_en[k] && m_fresh[k] >= WIDTH - 1 && word == int'(m_pat[k])) det[k] = 1'b1;
      end
    end
    if (c) begin
      m_hist.delete();
      for (int k = 0; k < NUM_PAT; k++) begin m_fresh[k] = 0; m_cnt[k] = 0; end
    end else if (v) begin
      m_hist.push_back(int'(b));
      if (m_hist.size() > WIDTH) void'(m_hist.pop_front());
      for (int k = 0; k < NUM_PAT; k++) begin
        if (det[k] && !overlap) m_fresh[k] = 0;
        else m_fresh[k]++;
        if (det[k] && m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
      end
    end
    if (we && idx < NUM_PAT) begin
      m_pat[idx] = p; m_en[idx] = e; m_fresh[idx] = 0;
    end
    ex.det = det;
    ex.hc  = '0;
`ifdef MULTI_SEQ_HIT_COUNT_EN
    for (int k = 0; k < NUM_PAT; k++) ex.hc[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
`endif
    exp_q.push_back(ex);
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic cfg(input int idx, input logic [WIDTH-1:0] p, input logic e);
    step(1'b0, 1'b0, 1'b0, 1'b1, idx, p, e);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  // Asynchronous reset pulse between edges; outputs must be zero while it is held.
  task automatic pulse_reset();
    @(negedge clock); #1;
    reset_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    check("reset_det", 64'(detected), 64'(0));
    check("reset_hc", 64'(hit_count), 64'(0));
    @(posedge clock); #1;
    check("reset_det_hold", 64'(detected), 64'(0));
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses_before;
    model_reset();
    #3;
    check("por_det", 64'(detected), 64'(0));
    check("por_hc", 64'(hit_count), 64'(0));
    @(negedge clock); #1;
    reset_n = 1'b1;

    // Overlapping detection of 1101 with a non-matching 1001 channel.
    cfg(0, 4'b1101, 1'b1);
    cfg(1, 4'b1001, 1'b1);
    overlap = 1'b1;
    pulses_before = n_pulses;
    stream(32'b1101101, 7);
    idle();
    check("overlap_pulse_cycles", 64'(n_pulses - pulses_before), 64'(2));

    // Non-overlapping on the same streams.
    overlap = 1'b0;
    do_clear();
    stream(32'b1101101, 7);
    do_clear();
    stream(32'b11011101, 8);

    // Valid gaps hold state.
    do_clear();
    stream(32'b100, 3);
    repeat (5) idle();
    bit_in(1'b1);

    // Shared pattern, then rewrite channel 1 on the completing bit.
    cfg(0, 4'b1001, 1'b1);
    do_clear();
    stream(32'b100, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b0110, 1'b1);
    stream(32'b0110, 4);
    stream(32'b0110, 4);

    // Reset mid-stream discards partial history and configuration.
    cfg(0, 4'b1101, 1'b1);
    stream(32'b110, 3);
    pulse_reset();
    cfg(0, 4'b1101, 1'b1);
    bit_in(1'b1);
    stream(32'b1101, 4);

    // Clear coincident with the completing bit.
    do_clear();
    stream(32'b110, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
    idle();

    // Counter saturation with five non-overlapping matches.
    overlap = 1'b0;
    do_clear();
    repeat (5) stream(32'b1101, 4);

    // Random traffic with occasional clears and reconfiguration.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 64 == 0) overlap = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 2) do_clear();
      else if (r < 5) cfg($urandom_range(0, NUM_PAT - 1), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
      else if (r < 7) step(1'($urandom), 1'b1, 1'b0, 1'b1, $urandom_range(0, NUM_PAT - 1),
                           WIDTH'($urandom), 1'b1);
      else if (r < 25) idle();
      else if (r < 26) step(1'($urandom), 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
      else bit_in(1'($urandom));
    end

    @(negedge clock); #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_seq_detect.md
# multi_seq_detect

Parametrised serial multi-pattern detector that watches one bit stream for up to `NUM_PAT` runtime-programmable patterns of `WIDTH` bits each. It generalises the fixed two-pattern 4-bit detectors used elsewhere in the design:

- patterns are loaded through a configuration port;
- each pattern can be enabled on its own;
- overlapping or non-overlapping matching is selected at run time;
- gaps in the stream are handled with a valid qualifier;
- optional per-pattern saturating hit counters can be compiled in.

## Interface
- `WIDTH`, 4: pattern length in bits; legal range 2..16.
- `NUM_PAT`, 2: number of pattern channels; legal range 1..8.
- `CNT_W`, 8: width of each hit counter.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in` input 1: serial data bit.
- `in_valid` input 1: `in` is sampled only when this is high.
- `clear` input 1: synchronous flush of history, fill counts, `detected` and hit counters.
- `overlap` input 1: 1 = overlapping matches, 0 = non-overlapping.
- `cfg_we` input 1: pattern write strobe.
- `cfg_idx` input clog2(`NUM_PAT`) (min 1): channel to write.
- `cfg_pattern` input `WIDTH`: pattern value; MSB is the first bit received.
- `cfg_en` input 1: enable bit for the written channel.
- `detected` output `NUM_PAT`: one-cycle match pulse per channel.
- `hit_count` output `NUM_PAT`*`CNT_W`: per-channel counters; channel k occupies bits [k*`CNT_W` +: `CNT_W`].

## Operation
- **History register.** `hist[WIDTH-1:0]`; the newest bit is at the LSB.
  - On an accepted bit, `hist <= {hist[WIDTH-2:0], in}`.
  - The candidate word is `{hist[WIDTH-2:0], in}`.
- **Fill count per channel.** `fill[k]` has width clog2(`WIDTH`+1).
  - It increments on each accepted bit and saturates at `WIDTH`.
  - It gates matches, so no match can occur before `WIDTH` bits have arrived.
- **Match on channel k.** Requires all of the following:
  - `in_valid` = 1;
  - `en[k]` = 1;
  - `fill[k]` >= `WIDTH`-1;
  - candidate == `pat[k]`.
- **After a match on channel k:**
  - If `overlap` = 1, `fill[k]` stays saturated, so matches may share bits.
  - If `overlap` = 0, `fill[k]` is set to 0, so the next match on k needs `WIDTH` fresh bits.
  - Other channels are unaffected.
- **Multiple matches.** Several channels may match on the same bit; every matching channel pulses.
- **`in_valid` low.** History, fill counts and counters hold; `detected` returns to 0.
- **Configuration write.** `cfg_we` = 1 writes `pat[cfg_idx]` and `en[cfg_idx]`, and sets `fill[cfg_idx]` to 0.
  - A match evaluated in the same cycle uses the old pattern and old enable; `detected` may still pulse.
  - The `fill` reset takes priority over the post-match update.
  - An out-of-range `cfg_idx` is ignored.
- **`clear`.** Zeroes `hist`, all `fill`, `detected` and `hit_count`. Patterns and enables are retained.
  - `clear` has priority over an accepted bit in the same cycle; that bit is dropped.
  - `cfg_we` in the same cycle still writes `pat` and `en`.
- **Reset values** (while `reset_n` = 0):
  - `hist` = 0, all `fill` = 0, all `pat` = 0, all `en` = 0;
  - `detected` = 0, `hit_count` = 0.
- **Reset mid-stream.** Asserting `reset_n` in the middle of a stream discards the partial history; detection after release needs `WIDTH` new bits.

## Timing
- The bit accepted at rising edge t produces `detected[k]` = 1 from edge t until edge t+1. The output is registered; latency is 1 edge.
- `detected` never stays high longer than one cycle per accepted bit, even when matches occur on back-to-back bits.
- `hit_count[k]` updates on the same edge as `detected[k]`.
- A configuration write at edge t affects the bit accepted at edge t+1 onward.
- Reset is asynchronous on assertion. The first bit is accepted at the first rising edge with `reset_n` = 1.

## Configuration
- **Macro: `MULTI_SEQ_HIT_COUNT_EN`.**
- **Defined:** each channel has a `CNT_W`-bit counter.
  - It increments on every `detected[k]` pulse.
  - It saturates at 2^`CNT_W`-1 and does not wrap.
  - It is cleared by reset or `clear`.
- **Undefined:** no counter registers are built, and `hit_count` is tied to 0. The port list is identical in both builds.

## Test plan
- **Overlap on.** `WIDTH`=4, `NUM_PAT`=2, pat0=1101 enabled, pat1=1001 enabled, `overlap`=1. Stream 1101101 -> `detected[0]` pulses after bits 4 and 7; `detected[1]` never pulses.
- **Overlap off, same stream.** Stream 1101101 -> `detected[0]` pulses after bit 4 only. Stream 11011101 -> pulses after bits 4 and 8.
- **Valid gaps.** Stream 1,0,0 valid, then `in_valid`=0 for 5 cycles, then 1 -> `detected[1]` pulses once, on the edge that accepts the final 1. No pulse occurs during the gap.
- **Shared pattern and mid-stream config.** pat0 = pat1 = 1001 -> both bits of `detected` pulse together. Rewrite pat1=0110 on the edge that accepts the completing bit -> that pulse still occurs; pat1 needs 4 fresh bits afterwards.
- **Reset and clear mid-stream.** Pulse `reset_n` low after bits 110 of 1101 -> no pulse after the following 1; all outputs are 0 during reset. Assert `clear` with bit 4 of 1101 -> no pulse; `hit_count` = 0.
- **Counter saturation** (macro defined, `CNT_W`=2). Five 1101 matches with `overlap`=0 -> `hit_count[0]` reads 1,2,3,3,3. With the macro undefined, `hit_count` stays 0.
